// File: rtl/mac_pkg.sv
// Shared defaults and coefficient tables for the multiply-accumulate demo engine.
package mac_pkg;

  localparam int unsigned DEF_W     = 8;
  localparam int unsigned DEF_DEPTH = 4;
  localparam int unsigned DEF_OUT_W = 18;
  localparam int unsigned DEF_IDX_W = $clog2(DEF_DEPTH);

  typedef logic [DEF_IDX_W-1:0] idx_t;

  // Entry i lives at bits [i*W +: W]; frame sum of A.B is 70.
  localparam logic [DEF_DEPTH*DEF_W-1:0] A_TBL = {8'd4, 8'd3, 8'd2, 8'd1};
  localparam logic [DEF_DEPTH*DEF_W-1:0] B_TBL = {8'd8, 8'd7, 8'd6, 8'd5};

endpackage

// File: rtl/mac_coef_rom.sv
// Combinational coefficient lookup: table index -> {A[idx], B[idx]}.
module mac_coef_rom
  import mac_pkg::*;
#(
  parameter int unsigned             W      = DEF_W,
  parameter int unsigned             DEPTH  = DEF_DEPTH,
  parameter int unsigned             IDX_W  = $clog2(DEPTH),
  parameter logic [DEPTH*W-1:0]      A_COEF = A_TBL,
  parameter logic [DEPTH*W-1:0]      B_COEF = B_TBL
) (
  input  logic [IDX_W-1:0] idx,
  output logic [W-1:0]     a,
  output logic [W-1:0]     b
);

  assign a = A_COEF[idx*W +: W];
  assign b = B_COEF[idx*W +: W];

endmodule

// File: rtl/mac_unit.sv
// Free-running dot-product engine: one table term per clock, registered multiply,
// then accumulate; the accumulator restarts on the first term of every frame.
module mac_unit
  import mac_pkg::*;
#(
  parameter int unsigned        W      = DEF_W,
  parameter int unsigned        DEPTH  = DEF_DEPTH,
  parameter int unsigned        OUT_W  = DEF_OUT_W,
  parameter logic [DEPTH*W-1:0] A_COEF = A_TBL,
  parameter logic [DEPTH*W-1:0] B_COEF = B_TBL
) (
  input  logic             clk,
  input  logic             rst,
  output logic [OUT_W-1:0] out,
  output logic             frame_done
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [2*W-1:0]   prod_q, prod_d;
  logic             prod_vld_q;
  logic             prod_first_q, prod_first_d;
  logic             prod_last_q, prod_last_d;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic             done_q, done_d;
  logic [W-1:0]     coef_a, coef_b;

  mac_coef_rom #(
    .W      (W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W),
    .A_COEF (A_COEF),
    .B_COEF (B_COEF)
  ) u_rom (
    .idx (idx_q),
    .a   (coef_a),
    .b   (coef_b)
  );

  // Stage 1: look up and multiply the current term; DEPTH is a power of two so idx wraps.
  always_comb begin
    idx_d        = idx_q + 1'b1;
    prod_d       = (2*W)'(coef_a) * (2*W)'(coef_b);
    prod_first_d = (idx_q == '0);
    prod_last_d  = (idx_q == IDX_W'(DEPTH - 1));
  end

  // Stage 2: the first term of a frame replaces the sum rather than adding to it.
  always_comb begin
    acc_d  = acc_q;
    done_d = 1'b0;
    if (prod_vld_q) begin
      acc_d  = prod_first_q ? OUT_W'(prod_q) : acc_q + OUT_W'(prod_q);
      done_d = prod_last_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q        <= '0;
      prod_q       <= '0;
      prod_vld_q   <= 1'b0;
      prod_first_q <= 1'b0;
      prod_last_q  <= 1'b0;
      acc_q        <= '0;
      done_q       <= 1'b0;
    end else begin
      idx_q        <= idx_d;
      prod_q       <= prod_d;
      prod_vld_q   <= 1'b1;
      prod_first_q <= prod_first_d;
      prod_last_q  <= prod_last_d;
      acc_q        <= acc_d;
      done_q       <= done_d;
    end
  end

  assign out        = acc_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_mac_unit.sv
// Directed bench for mac_unit: default tables plus an all-255 table variant.
module tb_mac_unit;

  logic        clk;
  logic        rst;
  logic [17:0] out;
  logic        frame_done;
  logic [17:0] out_big;
  logic        frame_done_big;

  int tests;
  int failed;
  int k;         // non-reset edges since the last reset edge
  int done_cnt;

  int seq     [4] = '{5, 17, 38, 70};
  int seq_big [4] = '{65025, 130050, 195075, 260100};

  mac_unit dut (
    .clk        (clk),
    .rst        (rst),
    .out        (out),
    .frame_done (frame_done)
  );

  mac_unit #(
    .A_COEF ({8'd255, 8'd255, 8'd255, 8'd255}),
    .B_COEF ({8'd255, 8'd255, 8'd255, 8'd255})
  ) dut_big (
    .clk        (clk),
    .rst        (rst),
    .out        (out_big),
    .frame_done (frame_done_big)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: got %0d expected %0d (k=%0d)", tag, obs, exp, k);
    end
  endtask

  // Drive rst, advance one edge, then check both DUTs against the frame model.
  task automatic tick(input logic r);
    int exp_out, exp_big;
    logic exp_done;
    rst = r;
    @(posedge clk);
    #1;
    if (r) k = 0;
    else k++;
    exp_out  = (k < 2) ? 0 : seq[(k - 2) % 4];
    exp_big  = (k < 2) ? 0 : seq_big[(k - 2) % 4];
    exp_done = (k >= 5) && (((k - 5) % 4) == 0);
    if (frame_done === 1'b1) done_cnt++;
    check("out", 32'(out), 32'(exp_out));
    check("frame_done", 32'(frame_done), 32'(exp_done));
    check("out_max", 32'(out <= 18'd70), 32'd1);
    check("big_out", 32'(out_big), 32'(exp_big));
    check("big_frame_done", 32'(frame_done_big), 32'(exp_done));
  endtask

  initial begin
    tests    = 0;
    failed   = 0;
    k        = 0;
    done_cnt = 0;
    rst      = 1'b1;

    // Reset for two edges, then three full frames.
    tick(1'b1);
    tick(1'b1);
    for (int i = 0; i < 13; i++) tick(1'b0);
    check("pulse_count_3_frames", 32'(done_cnt), 32'd3);

    // Advance to out==17 then hit reset mid-frame.
    tick(1'b0);
    tick(1'b0);
    check("mid_frame_out_17", 32'(out), 32'd17);
    tick(1'b1);
    check("mid_reset_out_0", 32'(out), 32'd0);
    for (int i = 0; i < 5; i++) tick(1'b0);
    check("restart_frame_sum", 32'(out), 32'd70);

    // Long reset: everything stays cleared.
    for (int i = 0; i < 10; i++) tick(1'b1);
    check("long_reset_out_0", 32'(out), 32'd0);

    // Release again and run through a frame boundary into the next frame.
    done_cnt = 0;
    for (int i = 0; i < 8; i++) tick(1'b0);
    check("final_pulse_count", 32'(done_cnt), 32'd1);
    check("big_sum_no_wrap_seen", 32'(out_big), 32'd195075);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, expected finish within 100000");
    $fatal(1, "timeout");
  end

endmodule
